// File: rtl/fifo_tx_serializer_pkg.sv
// fifo_tx_serializer shared types and helpers.
// State encoding and frame-length math.
package fifo_tx_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // Clock cycles in one frame: start + data bits + stop bits.
  function automatic int frame_len(
    input int dw,
    input int bc,
    input int sb
  );
    return bc * (1 + dw + sb);
  endfunction

endpackage

// File: rtl/fifo_tx_serializer_timer.sv
// tx_bit_timer: down-counter pacing serial bit periods.
// Terminal flag is high on the last cycle of a period.
module tx_bit_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_term
);

  logic [W-1:0] r_cnt;

  // Load a new period length, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_term = (r_cnt == '0);

endmodule

// File: rtl/fifo_tx_serializer.sv
// fifo_tx_serializer: pops FIFO words and sends them
// as start / LSB-first data / stop frames on io_tx.
module fifo_tx_serializer
  import fifo_tx_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 2,
  parameter int BIT_CYCLES = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] io_fifo_dout,
  input  logic                  io_fifo_empty,
  output logic                  io_fifo_pop,
  input  logic                  io_enable,
  output logic                  io_tx,
  output logic                  io_busy,
  output logic [7:0]            io_frames
);

  localparam int STOP_CYC =
    frame_len(DATA_WIDTH, BIT_CYCLES, STOP_BITS)
    - BIT_CYCLES * (1 + DATA_WIDTH);
  localparam int TW =
    $clog2(STOP_CYC > 2 ? STOP_CYC : 2);
  localparam int IW =
    $clog2(DATA_WIDTH > 2 ? DATA_WIDTH : 2);

  localparam logic [TW-1:0] BIT_LD   = TW'(BIT_CYCLES - 1);
  localparam logic [TW-1:0] STOP_LD  = TW'(STOP_CYC - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

  tx_state_e             r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [IW-1:0]         r_idx;
  logic                  r_tx;
  logic [7:0]            r_frames;

  logic                  w_term;
  logic                  w_pop;
  logic                  w_load;
  logic                  w_last_bit;
  logic [TW-1:0]         w_load_val;
  logic [DATA_WIDTH-1:0] w_shifted;

  assign w_last_bit = (r_idx == LAST_IDX);
  assign w_shifted  = r_shift >> 1;

  assign w_pop = ((r_state == IDLE) ||
                  ((r_state == STOP) && w_term))
                 && io_enable && !io_fifo_empty;

  assign w_load = w_pop ||
                  ((r_state != IDLE) && w_term);

  assign w_load_val =
    ((r_state == DATA) && w_last_bit) ? STOP_LD : BIT_LD;

  tx_bit_timer #(
    .W (TW)
  ) u_timer (
    .clk        (clk),
    .rst_n      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_term     (w_term)
  );

  // Frame sequencer with registered line output and frame counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_idx    <= '0;
      r_tx     <= 1'b1;
      r_frames <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_state <= START;
            r_shift <= io_fifo_dout;
            r_tx    <= 1'b0;
          end
        end
        START: begin
          if (w_term) begin
            r_state <= DATA;
            r_idx   <= '0;
            r_tx    <= r_shift[0];
          end
        end
        DATA: begin
          if (w_term) begin
            if (w_last_bit) begin
              r_state <= STOP;
              r_tx    <= 1'b1;
            end else begin
              r_idx   <= r_idx + IW'(1);
              r_shift <= w_shifted;
              r_tx    <= w_shifted[0];
            end
          end
        end
        STOP: begin
          if (w_term) begin
            r_frames <= r_frames + 8'd1;
            if (w_pop) begin
              r_state <= START;
              r_shift <= io_fifo_dout;
              r_tx    <= 1'b0;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_fifo_pop = w_pop;
  assign io_tx       = r_tx;
  assign io_busy     = (r_state != IDLE);
  assign io_frames   = r_frames;

endmodule

// File: doc/fifo_tx_serializer.md
# fifo_tx_serializer

Read-side companion for the FiFo block. It drains words through the FIFO pop interface (dout/empty/pop) and sends each word on a single-wire line as a frame: start bit, DATA_WIDTH data bits LSB-first, then stop bit(s). It connects directly to a FiFo instance's io_dout/io_empty/io_pop and is the block's consumer, not a second buffer.

## Interface
- DATA_WIDTH, 2, bits per FIFO word; must be >= 1.
- BIT_CYCLES, 4, clock cycles per serial bit; must be >= 1.
- STOP_BITS, 1, stop bits per frame; must be >= 1.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = in reset.
- io_fifo_dout  in  DATA_WIDTH  FIFO head word; combinational, valid while io_fifo_empty=0.
- io_fifo_empty  in  1  FIFO empty flag.
- io_fifo_pop  out  1  pop strobe; one cycle per word consumed.
- io_enable  in  1  permits new frames to start.
- io_tx  out  1  serial line; idle high.
- io_busy  out  1  1 while a frame is in progress.
- io_frames  out  8  count of completed frames, wraps mod 256.

## Operation
- The FSM has four states: IDLE, START, DATA, STOP.
- Pop condition: (state==IDLE, or last cycle of STOP) and io_enable=1 and io_fifo_empty=0.
  - io_fifo_pop is combinational from state, timer, io_enable and io_fifo_empty.
  - Pop is never asserted while empty=1.
- In a pop cycle, io_fifo_dout is captured into the shift register. The next state is START.
- START drives io_tx=0 for BIT_CYCLES cycles, then goes to DATA.
- DATA drives shift-register bit 0 for BIT_CYCLES cycles, then shifts right.
  - A bit index counts 0..DATA_WIDTH-1.
  - After the last bit, the next state is STOP.
- STOP drives io_tx=1 for STOP_BITS*BIT_CYCLES cycles.
  - In its last cycle, io_frames increments.
  - The next state is START if the pop condition holds, otherwise IDLE.
- io_busy = (state != IDLE).
- Deasserting io_enable mid-frame does not abort the frame. The current frame completes, and no further pop occurs.
- io_fifo_dout is ignored in every cycle except the pop cycle.
- Reset (asynchronous) takes effect immediately:
  - state=IDLE, io_tx=1, io_busy=0, io_fifo_pop=0, io_frames=0, timers and shift register cleared.
  - A frame in progress is abandoned, and its popped word is lost.

## Timing
- Frame length F = BIT_CYCLES*(1+DATA_WIDTH+STOP_BITS); with defaults, F = 16.
- io_tx and io_busy are registered outputs.
- Single frame, pop in cycle T:
  - Start bit occupies T+1..T+BIT_CYCLES.
  - Data bit i occupies T+1+BIT_CYCLES*(1+i) for BIT_CYCLES cycles.
  - Stop bit(s) occupy the last STOP_BITS*BIT_CYCLES cycles, ending at T+F.
  - io_frames shows the new value at T+F+1.
- Back-to-back frames: the next pop occurs in cycle T+F and its start bit begins at T+F+1. io_tx has no idle gap and io_busy stays 1.
- Latency from empty 1->0 (with IDLE and enable=1) to pop: 0 cycles, same cycle. Latency to the start-bit edge on io_tx: 1 cycle.
- io_frames wraps from 255 to 0.
- Internal counter widths:
  - Bit timer: clog2(max(BIT_CYCLES*STOP_BITS,2)) bits.
  - Bit index: clog2(max(DATA_WIDTH,2)) bits.
- No combinational path from io_fifo_dout to any output.

## Structure
- A shared package holds:
  - State encoding constants IDLE=0, START=1, DATA=2, STOP=3 (2-bit).
  - A frame-length function F(DATA_WIDTH,BIT_CYCLES,STOP_BITS), used by both RTL and bench.
- One sub-module, tx_bit_timer:
  - Down-counter with a load value.
  - Asserts a terminal flag on its last cycle.
  - Reloads on state change.

## Test plan
- Reset with defaults: reset=0 -> io_tx=1, io_busy=0, io_fifo_pop=0, io_frames=0. Hold after release with the FIFO empty -> outputs unchanged.
- Single word 2'b10, empty drops at T:
  - Pop=1 at T only.
  - io_tx = 0 (T+1..T+4), 0 (T+5..T+8), 1 (T+9..T+12), 1 (T+13..T+16).
  - io_frames=1 at T+17; io_busy=0 at T+17.
- Back-to-back 2'b01 then 2'b11 -> pops at T and T+16, io_tx continuous with no idle cycle, io_frames=2 at T+33.
- io_enable=0 with FIFO non-empty -> no pop for 50 cycles. Drop io_enable at T+5 of a frame -> frame completes through T+16, no pop at T+16.
- reset=0 asynchronously at T+6 of a frame -> io_tx=1 and io_busy=0 before the next edge. After release with a word available -> a new pop and a full, correct frame.
- BIT_CYCLES=1, DATA_WIDTH=2: stream 257 words -> pops every 4 cycles, io_frames wraps 255->0 and reads 1 after the 257th frame.
